// File: rtl/hdmi_src_sched_if.sv
// Encoder-side and source-side signals of the HDMI source scheduler.
// HDMI_SRC_SCHED_STATS_EN adds the underrun event counter output.
interface hdmi_src_sched_if #(
    parameter int BITS_PER_COLOR = 8
);
    localparam int PW = 3 * BITS_PER_COLOR;

    logic [1:0]    i_mode;
    logic          i_rd;
    logic          i_newline;
    logic          i_newframe;
    logic [PW-1:0] i_a_pixel;
    logic [PW-1:0] i_b_pixel;
    logic          i_b_valid;
    logic          o_a_rd;
    logic          o_b_rd;
    logic [PW-1:0] o_pixel;
    logic          o_sel;
    logic [1:0]    o_state;
    logic          o_underrun;
    logic [15:0]   o_frame_cnt;
`ifdef HDMI_SRC_SCHED_STATS_EN
    logic [15:0]   o_underrun_cnt;

    modport slave (
        input  i_mode, i_rd, i_newline, i_newframe, i_a_pixel, i_b_pixel, i_b_valid,
        output o_a_rd, o_b_rd, o_pixel, o_sel, o_state, o_underrun, o_frame_cnt,
        output o_underrun_cnt
    );
    modport master (
        output i_mode, i_rd, i_newline, i_newframe, i_a_pixel, i_b_pixel, i_b_valid,
        input  o_a_rd, o_b_rd, o_pixel, o_sel, o_state, o_underrun, o_frame_cnt,
        input  o_underrun_cnt
    );
`else
    modport slave (
        input  i_mode, i_rd, i_newline, i_newframe, i_a_pixel, i_b_pixel, i_b_valid,
        output o_a_rd, o_b_rd, o_pixel, o_sel, o_state, o_underrun, o_frame_cnt
    );
    modport master (
        output i_mode, i_rd, i_newline, i_newframe, i_a_pixel, i_b_pixel, i_b_valid,
        input  o_a_rd, o_b_rd, o_pixel, o_sel, o_state, o_underrun, o_frame_cnt
    );
`endif
endinterface

// File: rtl/hdmi_src_sched.sv
// Frame-synchronous scheduler sharing the encoder pixel stream between source A and B.
// Optional HDMI_SRC_SCHED_STATS_EN adds a saturating underrun event counter.
//
// state    | meaning
// SRC_A    | source A drives the encoder
// SRC_B    | source B drives the encoder (underrun colour when B not valid)
// FALLBACK | B underran last frame; A drives the encoder until holdoff expires
module hdmi_src_sched #(
    parameter int BITS_PER_COLOR = 8,
    parameter int DWELL_FRAMES   = 60,
    parameter int HOLDOFF_FRAMES = 4,
    parameter logic [3*BITS_PER_COLOR-1:0] UNDERRUN_COLOR = 24'hFF00FF
) (
    input logic               i_pixclk,
    input logic               i_reset_n,
    hdmi_src_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        SRC_A    = 2'b00,
        SRC_B    = 2'b01,
        FALLBACK = 2'b10
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_FRAMES - 1);

    state_t      state;
    logic        sel;
    logic        underrun;
    logic [15:0] frame_cnt;
    logic [15:0] dwell;
    logic [15:0] holdoff;
    logic [1:0]  mode_last;
    logic        underrun_evt;
    logic        underrun_seen;
    logic        unused_newline;

    // newline goes to the sources directly; the scheduler only needs frame timing
    assign unused_newline = bus.i_newline;

    assign underrun_evt  = bus.i_rd & sel & ~bus.i_b_valid;
    // an underrun in the newframe cycle itself still counts toward the ending frame
    assign underrun_seen = underrun | underrun_evt;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= SRC_A;
            sel       <= 1'b0;
            underrun  <= 1'b0;
            frame_cnt <= '0;
            dwell     <= '0;
            holdoff   <= '0;
            mode_last <= 2'b00;
        end else if (bus.i_newframe) begin
            frame_cnt <= frame_cnt + 16'd1;
            underrun  <= 1'b0;
            mode_last <= bus.i_mode;
            case (bus.i_mode)
                2'b00: begin
                    state   <= SRC_A;
                    sel     <= 1'b0;
                    dwell   <= '0;
                    holdoff <= '0;
                end
                2'b01: begin
                    state   <= SRC_B;
                    sel     <= 1'b1;
                    dwell   <= '0;
                    holdoff <= '0;
                end
                2'b10: begin
                    holdoff <= '0;
                    if (mode_last != 2'b10) begin
                        dwell <= '0;
                    end else if (dwell == DWELL_LAST) begin
                        dwell <= '0;
                        if (state == SRC_B) begin
                            state <= SRC_A;
                            sel   <= 1'b0;
                        end else begin
                            state <= SRC_B;
                            sel   <= 1'b1;
                        end
                    end else begin
                        dwell <= dwell + 16'd1;
                    end
                end
                default: begin
                    dwell <= '0;
                    case (state)
                        SRC_B: begin
                            if (underrun_seen) begin
                                state   <= FALLBACK;
                                sel     <= 1'b0;
                                holdoff <= HOLD_LAST;
                            end
                        end
                        FALLBACK: begin
                            if (holdoff == '0) begin
                                state <= SRC_B;
                                sel   <= 1'b1;
                            end else begin
                                holdoff <= holdoff - 16'd1;
                            end
                        end
                        default: begin
                            state <= SRC_B;
                            sel   <= 1'b1;
                        end
                    endcase
                end
            endcase
        end else if (underrun_evt) begin
            underrun <= 1'b1;
        end
    end

`ifdef HDMI_SRC_SCHED_STATS_EN
    logic [15:0] underrun_cnt;

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            underrun_cnt <= '0;
        end else if (underrun_evt && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

    assign bus.o_underrun_cnt = underrun_cnt;
`endif

    assign bus.o_a_rd      = bus.i_rd & ~sel;
    assign bus.o_b_rd      = bus.i_rd & sel;
    assign bus.o_pixel     = !sel         ? bus.i_a_pixel :
                             bus.i_b_valid ? bus.i_b_pixel : UNDERRUN_COLOR;
    assign bus.o_sel       = sel;
    assign bus.o_state     = state;
    assign bus.o_underrun  = underrun;
    assign bus.o_frame_cnt = frame_cnt;

endmodule

// File: tb/tb_hdmi_src_sched.sv
// Self-checking bench for hdmi_src_sched: scoreboard of per-cycle expected outputs
// from a frame-level reference model, plus directed checks from the test plan.
module tb_hdmi_src_sched;
    localparam int DW = 3;
    localparam int HO = 4;
    localparam logic [23:0] UC = 24'hFF00FF;

    typedef struct packed {
        logic        a_rd;
        logic        b_rd;
        logic [23:0] pixel;
        logic        sel;
        logic [1:0]  state;
        logic        under;
        logic [15:0] fc;
        logic [15:0] ucnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    // reference model state
    int          m_state;
    logic        m_under;
    logic [15:0] m_fc;
    int          m_dwell;
    int          m_hold;
    logic [1:0]  m_last;
    logic [15:0] m_ucnt;

    hdmi_src_sched_if #(.BITS_PER_COLOR(8)) bus();

    hdmi_src_sched #(
        .BITS_PER_COLOR(8),
        .DWELL_FRAMES(DW),
        .HOLDOFF_FRAMES(HO),
        .UNDERRUN_COLOR(UC)
    ) dut (
        .i_pixclk(clk),
        .i_reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_under = 1'b0;
        m_fc    = '0;
        m_dwell = 0;
        m_hold  = 0;
        m_last  = 2'b00;
        m_ucnt  = '0;
    endtask

    // Drive one cycle's inputs just after a rising edge, queue the expected
    // outputs, then advance the model across the next rising edge.
    task automatic cyc(input logic rd, input logic nf, input logic bv, input logic [1:0] md);
        exp_t e;
        logic msel;
        logic evt;
        bus.i_rd       = rd;
        bus.i_newframe = nf;
        bus.i_newline  = nf;
        bus.i_b_valid  = bv;
        bus.i_mode     = md;
        msel    = (m_state == 1);
        e.a_rd  = rd & ~msel;
        e.b_rd  = rd & msel;
        e.pixel = !msel ? bus.i_a_pixel : (bv ? bus.i_b_pixel : UC);
        e.sel   = msel;
        e.state = 2'(m_state);
        e.under = m_under;
        e.fc    = m_fc;
        e.ucnt  = m_ucnt;
        sb.push_back(e);
        evt = rd & msel & ~bv;
        @(posedge clk);
        if (rst_n) begin
            if (evt && m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
            if (nf) begin
                m_fc = m_fc + 16'd1;
                case (md)
                    2'b00: m_state = 0;
                    2'b01: m_state = 1;
                    2'b10: begin
                        if (m_last != 2'b10) m_dwell = 0;
                        else if (m_dwell == DW - 1) begin
                            m_dwell = 0;
                            m_state = (m_state == 1) ? 0 : 1;
                        end else m_dwell++;
                    end
                    default: begin
                        if (m_state == 1 && (m_under || evt)) begin
                            m_state = 2;
                            m_hold  = HO - 1;
                        end else if (m_state == 2) begin
                            if (m_hold == 0) m_state = 1;
                            else m_hold--;
                        end else if (m_state == 0) m_state = 1;
                    end
                endcase
                if (md != 2'b11) m_hold = 0;
                if (md != 2'b10) m_dwell = 0;
                m_last  = md;
                m_under = 1'b0;
            end else if (evt) begin
                m_under = 1'b1;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq("a_rd", 32'(bus.o_a_rd), 32'(e.a_rd));
            check_eq("b_rd", 32'(bus.o_b_rd), 32'(e.b_rd));
            check_eq("pixel", 32'(bus.o_pixel), 32'(e.pixel));
            check_eq("sel", 32'(bus.o_sel), 32'(e.sel));
            check_eq("state", 32'(bus.o_state), 32'(e.state));
            check_eq("underrun", 32'(bus.o_underrun), 32'(e.under));
            check_eq("frame_cnt", 32'(bus.o_frame_cnt), 32'(e.fc));
`ifdef HDMI_SRC_SCHED_STATS_EN
            check_eq("underrun_cnt", 32'(bus.o_underrun_cnt), 32'(e.ucnt));
`endif
        end
    end

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        cyc(1'b1, 1'b0, 1'b1, bus.i_mode);
        rst_n = 1'b1;
    endtask

    initial begin
        logic dwell_seq[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] fb_seq[5] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        checks = 0;
        errors = 0;
        model_reset();
        rst_n          = 1'b0;
        bus.i_mode     = 2'b00;
        bus.i_rd       = 1'b0;
        bus.i_newline  = 1'b0;
        bus.i_newframe = 1'b0;
        bus.i_a_pixel  = 24'h123456;
        bus.i_b_pixel  = 24'hABCDEF;
        bus.i_b_valid  = 1'b1;
        @(posedge clk);
        #1;

        // reset phase and mode 00
        for (int i = 0; i < 3; i++) cyc(1'(i % 2), 1'b0, 1'b1, 2'b00);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'(i % 2), 1'b0, 1'b1, 2'b00);
        check_eq("reset_state", 32'(bus.o_state), 32'h0);
        check_eq("reset_pixel", 32'(bus.o_pixel), 32'h123456);

        // mode 01 mid-frame waits for newframe
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 2'b01);
        check_eq("mid_frame_sel", 32'(bus.o_sel), 32'h0);
        cyc(1'b1, 1'b1, 1'b1, 2'b01);
        check_eq("nf_sel_b", 32'(bus.o_sel), 32'h1);
        check_eq("nf_pixel_b", 32'(bus.o_pixel), 32'hABCDEF);
        check_eq("nf_b_rd", 32'(bus.o_b_rd), 32'h1);

        // auto-cycle: seven frames from reset
        bus.i_mode = 2'b10;
        pulse_reset();
        for (int f = 0; f < 7; f++) begin
            cyc(1'b0, 1'b1, 1'b1, 2'b10);
            check_eq("dwell_sel", 32'(bus.o_sel), 32'(dwell_seq[f]));
            for (int i = 0; i < 3; i++) cyc(1'(i % 2), 1'b0, 1'b1, 2'b10);
        end
        check_eq("dwell_frames", 32'(bus.o_frame_cnt), 32'd7);

        // B with fallback: single underrun read
        bus.i_mode = 2'b11;
        pulse_reset();
        cyc(1'b0, 1'b1, 1'b1, 2'b11);
        cyc(1'b1, 1'b0, 1'b1, 2'b11);
        cyc(1'b1, 1'b0, 1'b0, 2'b11);
        check_eq("urun_pixel", 32'(bus.o_pixel), 32'(UC));
        check_eq("urun_flag", 32'(bus.o_underrun), 32'h1);
        cyc(1'b0, 1'b0, 1'b1, 2'b11);
        for (int f = 0; f < 5; f++) begin
            cyc(1'b0, 1'b1, 1'b1, 2'b11);
            check_eq("fallback_state", 32'(bus.o_state), 32'(fb_seq[f]));
            for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 2'b11);
        end

        // underrun coincident with newframe
        cyc(1'b1, 1'b1, 1'b0, 2'b11);
        check_eq("nf_urun_state", 32'(bus.o_state), 32'h2);
        check_eq("nf_urun_flag", 32'(bus.o_underrun), 32'h0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 2'b11);

        // async reset mid-frame in SRC_B
        cyc(1'b0, 1'b1, 1'b1, 2'b01);
        cyc(1'b1, 1'b0, 1'b0, 2'b01);
        check_eq("pre_reset_sel", 32'(bus.o_sel), 32'h1);
        bus.i_rd = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_eq("async_sel", 32'(bus.o_sel), 32'h0);
        check_eq("async_b_rd", 32'(bus.o_b_rd), 32'h0);
        check_eq("async_a_rd", 32'(bus.o_a_rd), 32'h1);
        model_reset();
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 2'b01);
        rst_n = 1'b1;
        check_eq("post_reset_state", 32'(bus.o_state), 32'h0);
        check_eq("post_reset_fc", 32'(bus.o_frame_cnt), 32'h0);
`ifdef HDMI_SRC_SCHED_STATS_EN
        check_eq("post_reset_ucnt", 32'(bus.o_underrun_cnt), 32'h0);
`endif

        // randomised traffic across all modes
        for (int i = 0; i < 400; i++) begin
            bus.i_a_pixel = 24'($urandom);
            bus.i_b_pixel = 24'($urandom);
            cyc(1'($urandom_range(0, 1)), 1'(i % 6 == 0), 1'($urandom_range(0, 3) != 0),
                2'($urandom_range(0, 3)));
        end

        check_eq("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hdmi_src_sched.md
Name: hdmi_src_sched

Overview:
- Frame-synchronous scheduler that shares the HDMI encoder's pixel-read stream between two pixel sources: A (test-pattern generator) and B (video/framebuffer source).
- Routes the encoder's read strobe to the selected source only and muxes that source's pixel to the encoder.
- Switches source only on frame boundaries: manual select, automatic dwell-based cycling, or B with automatic fallback to A on underrun.
- Sits between the TMDS encoder and the pixel sources, on the pixel clock.

Parameters:
- BITS_PER_COLOR, 8, bits per colour channel; pixel width is 3*BITS_PER_COLOR ordered {red,grn,blu}.
- DWELL_FRAMES, 60, frames per source in auto-cycle mode (>=1).
- HOLDOFF_FRAMES, 4, frames spent in FALLBACK before retrying B (>=1).
- UNDERRUN_COLOR, 24'hFF00FF, pixel substituted when B is read while not valid (width 3*BITS_PER_COLOR).

Ports:
- i_pixclk  in  1  pixel clock; all state on rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_mode  in  2  00 force A, 01 force B, 10 auto-cycle A/B, 11 B with fallback.
- i_rd  in  1  encoder pixel read strobe.
- i_newline  in  1  encoder start-of-line pulse (forwarded externally to both sources).
- i_newframe  in  1  encoder start-of-frame pulse (forwarded externally to both sources).
- i_a_pixel  in  3*BITS_PER_COLOR  source A pixel.
- i_b_pixel  in  3*BITS_PER_COLOR  source B pixel.
- i_b_valid  in  1  source B has a pixel ready.
- o_a_rd  out  1  read strobe to A.
- o_b_rd  out  1  read strobe to B.
- o_pixel  out  3*BITS_PER_COLOR  pixel to encoder.
- o_sel  out  1  0 = A active, 1 = B active.
- o_state  out  2  00 SRC_A, 01 SRC_B, 10 FALLBACK.
- o_underrun  out  1  sticky within frame; set on a B underrun, cleared on i_newframe.
- o_frame_cnt  out  16  frames since reset, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: state SRC_A, o_sel 0, dwell and holdoff counters 0, o_underrun 0, o_frame_cnt 0.
- During reset, o_pixel = i_a_pixel and o_a_rd = i_rd.
- o_sel = 1 only in SRC_B. FALLBACK behaves as A.
- o_a_rd = i_rd & ~o_sel; o_b_rd = i_rd & o_sel. Combinational, zero latency.
- o_pixel is combinational:
  - o_sel = 0: i_a_pixel.
  - o_sel = 1 and i_b_valid = 1: i_b_pixel.
  - o_sel = 1 and i_b_valid = 0: UNDERRUN_COLOR.
- Underrun event = i_rd & o_sel & ~i_b_valid; sets o_underrun the following cycle.
- i_mode is sampled only in a cycle with i_newframe = 1; state/o_sel change on that edge, so the new source supplies the frame's first pixel.
- In the i_newframe cycle: o_frame_cnt += 1, o_underrun <= 0. An underrun in that same cycle is still honoured for the fallback decision (captured via an internal pending flag), but o_underrun ends cleared.
- Next-state at i_newframe:
  - Mode 00: SRC_A.
  - Mode 01: SRC_B.
  - Mode 10: dwell counter increments. At DWELL_FRAMES-1 it clears and the state toggles SRC_A<->SRC_B (FALLBACK -> SRC_B). Entering mode 10 from another mode clears dwell without toggling.
  - Mode 11:
    - From SRC_B with an underrun in the ending frame: FALLBACK, holdoff loaded with HOLDOFF_FRAMES-1.
    - In FALLBACK: if holdoff = 0, go to SRC_B; else holdoff decrements.
    - From SRC_A: SRC_B.
- Leaving mode 11 while in FALLBACK: the next i_newframe obeys the new mode and holdoff is cleared.
- Without i_newframe, state never changes, regardless of i_mode or i_b_valid.
- Asynchronous reset mid-frame returns immediately to SRC_A. o_b_rd drops in the same cycle.

Optional Feature:
- Macro HDMI_SRC_SCHED_STATS_EN.
- When defined: adds output o_underrun_cnt (16 bits), which counts every underrun-event cycle. It saturates at 16'hFFFF, is reset to 0, and is not cleared per frame.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with mode 00, i_rd toggling, i_a_pixel = 24'h123456 -> o_pixel = 24'h123456, o_a_rd follows i_rd, o_b_rd = 0, o_state = 00.
- Mode 01 set mid-frame -> no change until the i_newframe cycle. Next cycle o_sel = 1, o_b_rd = i_rd, o_pixel = i_b_pixel.
- Mode 10, DWELL_FRAMES = 3, 7 frames -> o_sel sequence per frame is A,A,A,B,B,B,A. o_frame_cnt = 7.
- Mode 11 in SRC_B, i_b_valid = 0 for one read -> o_pixel = 24'hFF00FF that cycle, o_underrun = 1 next cycle. Next frame FALLBACK for HOLDOFF_FRAMES = 4 frames, then SRC_B.
- Underrun in the same cycle as i_newframe with mode 11 -> FALLBACK still entered, o_underrun = 0.
- Assert i_reset_n low mid-frame while in SRC_B -> o_sel = 0 and o_b_rd = 0 immediately. After release: state 00, o_frame_cnt = 0. With HDMI_SRC_SCHED_STATS_EN defined, o_underrun_cnt = 0.
